st7789_spi_rx: RTL and testbench
================================

# st7789_spi_rx

Passive ST7789 SPI receiver for the ESP32-to-display link. It oversamples the 4-wire SPI stream (SCK, MOSI, D/C, CSn) on the 25 MHz system clock and deserializes it into bytes. It decodes the CASET, RASET and RAMWR commands, then emits one RGB565 pixel write with its (x, y) coordinate per pixel. It sits beside the display passthrough in the top level and lets FPGA logic mirror the frame the ESP32 draws.

## Interface
- WIDTH, 240: panel columns; reset value of the column end is WIDTH-1.
- HEIGHT, 320: panel rows; reset value of the row end is HEIGHT-1.
- COORD_W, 9: width of x/y coordinates; 16-bit parameters are truncated to the low COORD_W bits.

- clk  in  1  system clock (25 MHz).
- rst  in  1  reset, asynchronous, active-high.
- spi_clk  in  1  SCK from ESP32, asynchronous; SPI mode 0 or 3 (MOSI sampled on rising edge).
- spi_mosi  in  1  serial data, MSB first.
- spi_dc  in  1  0 = command byte, 1 = data byte.
- spi_csn  in  1  chip select, active low.
- byte_valid  out  1  one-cycle strobe: a byte was received.
- byte_data  out  8  received byte.
- byte_dc  out  1  D/C level sampled with the byte's 8th bit.
- pix_valid  out  1  one-cycle strobe: a pixel was received.
- pix_x  out  COORD_W  pixel column.
- pix_y  out  COORD_W  pixel row.
- pix_data  out  16  RGB565, first byte in [15:8].

## Operation
- Synchronization:
  - All four SPI inputs pass through 2-flop synchronizers (s1, s2).
  - SCK has a third stage s3. A rising edge is s2 & ~s3.
  - MOSI, DC and CSn are taken from s2, so they stay aligned with the edge.
- Deserializer:
  - While csn_s2 = 0, each SCK rising edge shifts mosi_s2 into an 8-bit shift register and increments a 3-bit bit counter.
  - On the 8th bit, the full byte is loaded into byte_data together with byte_dc = dc_s2, and byte_valid pulses for one cycle.
  - While csn_s2 = 1, the bit counter is held at 0 and any partial byte is discarded. SCK edges are ignored.
  - Decoder state survives CSn toggling.
- Decoder states are IDLE, CASET, RASET and RAMWR.
  - Any command byte (dc = 0) selects the new state and clears the parameter index.
  - 0x2A selects CASET, 0x2B selects RASET, and 0x2C selects RAMWR. Every other command selects IDLE.
  - Entering RAMWR loads x <= xs, y <= ys and clears the half-pixel flag.
- CASET/RASET parameter bytes (dc = 1), by index:
  - 0: start[15:8]
  - 1: start[7:0]
  - 2: end[15:8]
  - 3: end[7:0]
  - The start/end registers (xs/xe or ys/ye) update only when index 3 completes. Bytes after index 3 are ignored.
  - A new command before index 3 leaves the old window intact.
- RAMWR data bytes:
  - The first byte is latched as the high half.
  - The second byte completes the pixel: pix_valid pulses with pix_x = x, pix_y = y and pix_data = {hi, lo}.
  - Then advance the position:
    - If x != xe: x + 1.
    - Otherwise: x <= xs, and y advances to y + 1, or wraps to ys if y == ye.
  - Writes continue without limit and wrap inside the window.
- IDLE data bytes produce byte_valid only.
- No bounds checking against WIDTH/HEIGHT. The behaviour of a reversed window (start > end) is undefined; the bench must not drive it.

## Timing
- Let edge N be the clk edge where s1 first captures SCK = 1.
  - The shift occurs at edge N+2.
  - For the 8th bit, byte_valid/byte_data/byte_dc register at edge N+2 and byte_valid is high for exactly one cycle.
  - pix_valid registers one cycle after the byte_valid of the pixel's low byte.
- SCK high and low phases must each last at least 2 clk periods (SCK ≤ 6.25 MHz).
- MOSI, DC and CSn must be stable from 1 clk before to 1 clk after the SCK rise.
- SCK rising in the same cycle as csn_s2 = 1 is ignored.
- Reset values:
  - Outputs: byte_valid = 0, pix_valid = 0, byte_data = 0, byte_dc = 0, pix_x = 0, pix_y = 0, pix_data = 0.
  - Internal state: decoder IDLE, xs = ys = 0, xe = WIDTH-1, ye = HEIGHT-1, x = y = 0, bit counter 0.
  - The synchronizers reset to SCK = 0 and CSn = 1.
- Reset asserted mid-byte or mid-pixel discards the partial data and emits no strobe.

## Test plan
- Byte path: CSn low, send 0xA5 with DC = 1 at SCK = 1 MHz -> one byte_valid, byte_data = 0xA5, byte_dc = 1, pix_valid never asserts.
- Window and stream: CASET 0x0000,0x0001; RASET 0x000A,0x000B; RAMWR; 5 pixels 0x1111..0x5555 -> (x, y) sequence (0,10), (1,10), (0,11), (1,11), (0,10) with matching pix_data.
- Reset window: after reset, RAMWR plus two pixels -> (0,0), (1,0); a RAMWR pixel stream of 240 pixels ends at (239,0), and the 241st pixel lands at (0,1).
- Aborted byte: 5 bits sent, CSn raised, CSn lowered, full byte 0x3C -> exactly one byte_valid, with 0x3C.
- Command interrupt: CASET with only 2 parameter bytes, then RAMWR + 1 pixel -> pixel at the previous xs; a second RAMWR mid-pixel (one byte sent) restarts at (xs, ys) and emits no pixel for the orphaned byte.
- Async reset asserted for 1 clk during RAMWR mid-byte -> no strobes, outputs zero; the next RAMWR pixel appears at (0,0).

Source files
------------

// File: rtl/st7789_spi_rx.sv
// Passive ST7789 SPI snooper: oversamples SCK/MOSI/DC/CSn, rebuilds bytes and
// decodes CASET/RASET/RAMWR into per-pixel RGB565 writes with (x, y).
`timescale 1ns/1ps
module st7789_spi_rx #(
  parameter int WIDTH   = 240,
  parameter int HEIGHT  = 320,
  parameter int COORD_W = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               spi_clk,
  input  logic               spi_mosi,
  input  logic               spi_dc,
  input  logic               spi_csn,
  output logic               byte_valid,
  output logic [7:0]         byte_data,
  output logic               byte_dc,
  output logic               pix_valid,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic [15:0]        pix_data
);
  localparam logic [COORD_W-1:0] XE_RST = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] YE_RST = COORD_W'(HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, CASET, RASET, RAMWR} state_t;

  logic r_sck_s1, r_sck_s2, r_sck_s3;
  logic r_mosi_s1, r_mosi_s2, r_dc_s1, r_dc_s2, r_csn_s1, r_csn_s2;
  logic w_sck_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {r_sck_s1, r_sck_s2, r_sck_s3} <= '0;
      {r_mosi_s1, r_mosi_s2, r_dc_s1, r_dc_s2} <= '0;
      {r_csn_s1, r_csn_s2} <= 2'b11;
    end else begin
      {r_sck_s1, r_sck_s2, r_sck_s3} <= {spi_clk, r_sck_s1, r_sck_s2};
      {r_mosi_s1, r_mosi_s2} <= {spi_mosi, r_mosi_s1};
      {r_dc_s1, r_dc_s2}     <= {spi_dc, r_dc_s1};
      {r_csn_s1, r_csn_s2}   <= {spi_csn, r_csn_s1};
    end
  end

  assign w_sck_rise = r_sck_s2 & ~r_sck_s3;

  logic [6:0] r_shift;
  logic [2:0] r_bitcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift    <= '0;
      r_bitcnt   <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      byte_dc    <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (r_csn_s2) begin
        r_bitcnt <= '0;
      end else if (w_sck_rise) begin
        r_shift  <= {r_shift[5:0], r_mosi_s2};
        r_bitcnt <= r_bitcnt + 3'd1;
        if (r_bitcnt == 3'd7) begin
          byte_data  <= {r_shift, r_mosi_s2};
          byte_dc    <= r_dc_s2;
          byte_valid <= 1'b1;
        end
      end
    end
  end

  state_t r_state, w_state_nxt;
  logic   w_cmd, w_dat;

  assign w_cmd = byte_valid & ~byte_dc;
  assign w_dat = byte_valid &  byte_dc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_cmd) begin
      case (byte_data)
        8'h2A:   w_state_nxt = CASET;
        8'h2B:   w_state_nxt = RASET;
        8'h2C:   w_state_nxt = RAMWR;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  logic [2:0]         r_idx;
  logic [7:0]         r_start_hi, r_start_lo, r_end_hi, r_hi;
  logic               r_half;
  logic [COORD_W-1:0] r_xs, r_xe, r_ys, r_ye, r_x, r_y;
  logic [COORD_W-1:0] w_start, w_end;

  assign w_start = COORD_W'({r_start_hi, r_start_lo});
  assign w_end   = COORD_W'({r_end_hi, byte_data});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx      <= '0;
      r_start_hi <= '0;
      r_start_lo <= '0;
      r_end_hi   <= '0;
      r_hi       <= '0;
      r_half     <= 1'b0;
      r_xs       <= '0;
      r_ys       <= '0;
      r_xe       <= XE_RST;
      r_ye       <= YE_RST;
      r_x        <= '0;
      r_y        <= '0;
      pix_valid  <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_data   <= '0;
    end else begin
      pix_valid <= 1'b0;
      if (w_cmd) begin
        r_idx <= '0;
        if (byte_data == 8'h2C) begin
          r_x    <= r_xs;
          r_y    <= r_ys;
          r_half <= 1'b0;
        end
      end else if (w_dat) begin
        case (r_state)
          CASET, RASET: begin
            // Index saturates at 4 so trailing parameter bytes are dropped.
            if (r_idx != 3'd4) r_idx <= r_idx + 3'd1;
            case (r_idx)
              3'd0: r_start_hi <= byte_data;
              3'd1: r_start_lo <= byte_data;
              3'd2: r_end_hi   <= byte_data;
              3'd3: begin
                if (r_state == CASET) begin
                  r_xs <= w_start;
                  r_xe <= w_end;
                end else begin
                  r_ys <= w_start;
                  r_ye <= w_end;
                end
              end
              default: ;
            endcase
          end
          RAMWR: begin
            if (!r_half) begin
              r_hi   <= byte_data;
              r_half <= 1'b1;
            end else begin
              r_half    <= 1'b0;
              pix_valid <= 1'b1;
              pix_x     <= r_x;
              pix_y     <= r_y;
              pix_data  <= {r_hi, byte_data};
              if (r_x != r_xe) begin
                r_x <= r_x + 1'b1;
              end else begin
                r_x <= r_xs;
                r_y <= (r_y == r_ye) ? r_ys : r_y + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_st7789_spi_rx.sv
// Directed bench for st7789_spi_rx: drives SPI transactions and checks the
// byte and pixel strobes captured by a negedge monitor.
`timescale 1ns/1ps
module tb_st7789_spi_rx;
  localparam int HP_FAST = 120;  // 3 clk half-period
  localparam int HP_1MHZ = 500;

  logic       clk = 1'b0, rst = 1'b1;
  logic       spi_clk = 1'b0, spi_mosi = 1'b0, spi_dc = 1'b0, spi_csn = 1'b1;
  logic       byte_valid, byte_dc, pix_valid;
  logic [7:0] byte_data;
  logic [8:0] pix_x, pix_y;
  logic [15:0] pix_data;

  int checks = 0, failures = 0;

  typedef struct packed { logic [8:0] x; logic [8:0] y; logic [15:0] d; } pix_t;
  pix_t       pq[$];
  logic [8:0] bq[$];

  st7789_spi_rx #(.WIDTH(240), .HEIGHT(320), .COORD_W(9)) dut (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .spi_dc(spi_dc), .spi_csn(spi_csn), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_dc(byte_dc), .pix_valid(pix_valid),
    .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data)
  );

  always #20 clk = ~clk;

  always @(negedge clk) begin
    if (byte_valid) bq.push_back({byte_dc, byte_data});
    if (pix_valid)  pq.push_back({pix_x, pix_y, pix_data});
  end

  task automatic send_bits(input logic [7:0] b, input logic dc, input int n, input int hp);
    for (int i = 7; i > 7 - n; i--) begin
      spi_clk = 1'b0; spi_mosi = b[i]; spi_dc = dc;
      #(hp);
      spi_clk = 1'b1;
      #(hp);
    end
    spi_clk = 1'b0;
    #(hp);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dc);
    send_bits(b, dc, 8, HP_FAST);
  endtask

  task automatic send_pixel(input logic [15:0] d);
    send_byte(d[15:8], 1'b1);
    send_byte(d[7:0], 1'b1);
  endtask

  task automatic settle();
    repeat (8) @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #5 rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (byte_valid !== 1'b0) begin failures++; $display("FAIL reset_byte_valid got=%b exp=0", byte_valid); end
    checks++; if (pix_valid !== 1'b0) begin failures++; $display("FAIL reset_pix_valid got=%b exp=0", pix_valid); end
    checks++; if (byte_data !== 8'h00) begin failures++; $display("FAIL reset_byte_data got=%h exp=00", byte_data); end
    checks++; if (byte_dc !== 1'b0) begin failures++; $display("FAIL reset_byte_dc got=%b exp=0", byte_dc); end
    checks++; if (pix_x !== 9'd0) begin failures++; $display("FAIL reset_pix_x got=%0d exp=0", pix_x); end
    checks++; if (pix_y !== 9'd0) begin failures++; $display("FAIL reset_pix_y got=%0d exp=0", pix_y); end
    checks++; if (pix_data !== 16'h0) begin failures++; $display("FAIL reset_pix_data got=%h exp=0000", pix_data); end
  endtask

  task automatic test_byte_path();
    bq.delete(); pq.delete();
    spi_csn = 1'b0; #200;
    send_bits(8'hA5, 1'b1, 8, HP_1MHZ);
    settle();
    spi_csn = 1'b1; #200;
    checks++; if (bq.size() !== 1) begin failures++; $display("FAIL byte_count got=%0d exp=1", bq.size()); end
    if (bq.size() > 0) begin
      checks++; if (bq[0] !== 9'h1A5) begin failures++; $display("FAIL byte_a5 got={dc=%b,%h} exp={dc=1,a5}", bq[0][8], bq[0][7:0]); end
    end
    checks++; if (pq.size() !== 0) begin failures++; $display("FAIL byte_no_pix got=%0d exp=0", pq.size()); end
  endtask

  task automatic test_reset_window();
    int         idx[5] = '{0, 1, 238, 239, 240};
    logic [8:0] ex[5]  = '{9'd0, 9'd1, 9'd238, 9'd239, 9'd0};
    logic [8:0] ey[5]  = '{9'd0, 9'd0, 9'd0, 9'd0, 9'd1};
    bq.delete(); pq.delete();
    spi_csn = 1'b0; #200;
    send_byte(8'h2C, 1'b0);
    for (int i = 0; i < 241; i++) send_pixel(16'hC000 | 16'(i));
    settle();
    spi_csn = 1'b1; #200;
    checks++; if (pq.size() !== 241) begin failures++; $display("FAIL rstwin_count got=%0d exp=241", pq.size()); end
    for (int k = 0; k < 5; k++) begin
      if (pq.size() > idx[k]) begin
        checks++;
        if (pq[idx[k]] !== {ex[k], ey[k], 16'hC000 | 16'(idx[k])}) begin
          failures++;
          $display("FAIL rstwin_pix%0d got=(%0d,%0d,%h) exp=(%0d,%0d,%h)", idx[k],
                   pq[idx[k]].x, pq[idx[k]].y, pq[idx[k]].d, ex[k], ey[k], 16'hC000 | 16'(idx[k]));
        end
      end
    end
  endtask

  task automatic test_window();
    logic [8:0]  ex[5] = '{9'd0, 9'd1, 9'd0, 9'd1, 9'd0};
    logic [8:0]  ey[5] = '{9'd10, 9'd10, 9'd11, 9'd11, 9'd10};
    logic [15:0] ed[5] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
    bq.delete(); pq.delete();
    spi_csn = 1'b0; #200;
    send_byte(8'h2A, 1'b0);
    send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
    send_byte(8'h2B, 1'b0);
    send_byte(8'h00, 1'b1); send_byte(8'h0A, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h0B, 1'b1);
    send_byte(8'h2C, 1'b0);
    for (int i = 0; i < 5; i++) send_pixel(ed[i]);
    settle();
    checks++; if (pq.size() !== 5) begin failures++; $display("FAIL win_count got=%0d exp=5", pq.size()); end
    checks++; if (bq.size() !== 21) begin failures++; $display("FAIL win_bytes got=%0d exp=21", bq.size()); end
    for (int k = 0; k < 5; k++) begin
      if (pq.size() > k) begin
        checks++;
        if (pq[k] !== {ex[k], ey[k], ed[k]}) begin
          failures++;
          $display("FAIL win_pix%0d got=(%0d,%0d,%h) exp=(%0d,%0d,%h)", k,
                   pq[k].x, pq[k].y, pq[k].d, ex[k], ey[k], ed[k]);
        end
      end
    end
  endtask

  task automatic test_abort();
    bq.delete(); pq.delete();
    send_bits(8'hFF, 1'b1, 5, HP_FAST);
    spi_csn = 1'b1; #300;
    spi_csn = 1'b0; #300;
    send_byte(8'h3C, 1'b0);
    settle();
    checks++; if (bq.size() !== 1) begin failures++; $display("FAIL abort_count got=%0d exp=1", bq.size()); end
    if (bq.size() > 0) begin
      checks++; if (bq[0] !== 9'h03C) begin failures++; $display("FAIL abort_byte got=%h exp=03c", bq[0]); end
    end
  endtask

  task automatic test_interrupt();
    bq.delete(); pq.delete();
    send_byte(8'h2A, 1'b0);
    send_byte(8'h00, 1'b1); send_byte(8'h05, 1'b1);
    send_byte(8'h2C, 1'b0);
    send_pixel(16'hA1A1);
    send_byte(8'h77, 1'b1);
    send_byte(8'h2C, 1'b0);
    send_pixel(16'hB2B2);
    settle();
    checks++; if (pq.size() !== 2) begin failures++; $display("FAIL intr_count got=%0d exp=2", pq.size()); end
    if (pq.size() > 0) begin
      checks++; if (pq[0] !== {9'd0, 9'd10, 16'hA1A1}) begin failures++;
        $display("FAIL intr_pix0 got=(%0d,%0d,%h) exp=(0,10,a1a1)", pq[0].x, pq[0].y, pq[0].d); end
    end
    if (pq.size() > 1) begin
      checks++; if (pq[1] !== {9'd0, 9'd10, 16'hB2B2}) begin failures++;
        $display("FAIL intr_pix1 got=(%0d,%0d,%h) exp=(0,10,b2b2)", pq[1].x, pq[1].y, pq[1].d); end
    end
  endtask

  task automatic test_async_reset();
    send_byte(8'h2C, 1'b0);
    send_byte(8'hDE, 1'b1);
    settle();
    bq.delete(); pq.delete();
    send_bits(8'hAD, 1'b1, 4, HP_FAST);
    @(posedge clk); #5 rst = 1'b1; #40 rst = 1'b0;
    settle();
    spi_csn = 1'b1; #300;
    checks++; if (bq.size() + pq.size() !== 0) begin failures++;
      $display("FAIL arst_strobes got=%0d exp=0", bq.size() + pq.size()); end
    checks++; if ({byte_data, byte_dc, pix_x, pix_y, pix_data} !== '0) begin failures++;
      $display("FAIL arst_outputs got=%h/%b/%0d/%0d/%h exp=zero", byte_data, byte_dc, pix_x, pix_y, pix_data); end
    spi_csn = 1'b0; #300;
    send_byte(8'h2C, 1'b0);
    send_pixel(16'hBEEF);
    settle();
    checks++; if (pq.size() !== 1) begin failures++; $display("FAIL arst_count got=%0d exp=1", pq.size()); end
    if (pq.size() > 0) begin
      checks++; if (pq[0] !== {9'd0, 9'd0, 16'hBEEF}) begin failures++;
        $display("FAIL arst_pix got=(%0d,%0d,%h) exp=(0,0,beef)", pq[0].x, pq[0].y, pq[0].d); end
    end
  endtask

  initial begin
    test_reset();
    test_byte_path();
    test_reset_window();
    test_window();
    test_abort();
    test_interrupt();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
